// File: rtl/mem_seq_pkg.sv
// Shared definitions for the byte-serial memory sequencer: size codes,
// FSM state encoding and the request byte-count helper.
package mem_seq_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_CAP,
    WR,
    DONE
  } state_t;

  // Reserved size code 11 behaves as a word.
  function automatic logic [2:0] byte_count(input logic [1:0] size);
    case (size)
      SZ_BYTE: byte_count = 3'd1;
      SZ_HALF: byte_count = 3'd2;
      default: byte_count = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_extend.sv
// Combinational zero/sign extension of assembled load bytes.
// Sign extension is built only when MEM_SEQ_SIGNEXT_EN is defined.
module mem_load_extend
  import mem_seq_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] raw,
  input  logic [1:0]        size,
  input  logic              sign_en,
  output logic [DATA_W-1:0] ext
);

  logic fill_b;
  logic fill_h;

`ifdef MEM_SEQ_SIGNEXT_EN
  assign fill_b = sign_en & raw[7];
  assign fill_h = sign_en & raw[15];
`else
  logic unused_sign;
  assign unused_sign = sign_en;
  assign fill_b      = 1'b0;
  assign fill_h      = 1'b0;
`endif

  always_comb begin
    ext = raw;
    case (size)
      SZ_BYTE: ext = {{(DATA_W-8){fill_b}}, raw[7:0]};
      SZ_HALF: ext = {{(DATA_W-16){fill_h}}, raw[15:0]};
      default: ext = raw;
    endcase
  end

endmodule

// File: rtl/mem_byte_sequencer.sv
// Byte-serial RAM access sequencer with big-endian ordering and MFA/MOC
// handshake. Define MEM_SEQ_SIGNEXT_EN to enable signed sub-word loads.
module mem_byte_sequencer
  import mem_seq_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              MFA,
  input  logic              RW,
  input  logic [1:0]        SIZE,
  input  logic              SIGNED,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [DATA_W-1:0] WDATA,
  output logic [DATA_W-1:0] RDATA,
  output logic              MOC,
  output logic              RAM_EN,
  output logic              RAM_WE,
  output logic [ADDR_W-1:0] RAM_ADDR,
  output logic [7:0]        RAM_WDATA,
  input  logic [7:0]        RAM_RDATA
);

  state_t state;
  state_t next_state;

  logic [1:0]        cnt;
  logic [1:0]        nm1;
  logic [1:0]        size_q;
  logic              sign_q;
  logic [ADDR_W-1:0] base_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rbuf;
  logic [DATA_W-1:0] rbuf_shift;
  logic [DATA_W-1:0] ext;
  logic [DATA_W-1:0] rdata_q;

  logic [2:0]        n_req;
  logic [1:0]        nm1_req;
  logic [ADDR_W-1:0] base_req;
  logic [1:0]        wsel;
  logic              last;
  logic              accept;

  assign n_req      = byte_count(SIZE);
  assign nm1_req    = 2'(n_req - 3'd1);
  assign last       = (cnt == nm1);
  assign accept     = (state == IDLE) && MFA;
  assign rbuf_shift = {rbuf[DATA_W-9:0], RAM_RDATA};
  assign wsel       = nm1 - cnt;

  always_comb begin
    base_req = ADDR;
    case (SIZE)
      SZ_BYTE: base_req = ADDR;
      SZ_HALF: base_req = {ADDR[ADDR_W-1:1], 1'b0};
      default: base_req = {ADDR[ADDR_W-1:2], 2'b00};
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    RAM_EN     = 1'b0;
    RAM_WE     = 1'b0;
    MOC        = 1'b0;
    case (state)
      IDLE: begin
        if (MFA) next_state = RW ? RD_ADDR : WR;
      end
      RD_ADDR: begin
        RAM_EN     = 1'b1;
        next_state = RD_CAP;
      end
      RD_CAP: begin
        next_state = last ? DONE : RD_ADDR;
      end
      WR: begin
        RAM_EN = 1'b1;
        RAM_WE = 1'b1;
        if (last) next_state = DONE;
      end
      DONE: begin
        MOC = 1'b1;
        if (!MFA) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt     <= '0;
      nm1     <= '0;
      size_q  <= '0;
      sign_q  <= 1'b0;
      base_q  <= '0;
      wdata_q <= '0;
      rbuf    <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        cnt     <= '0;
        nm1     <= nm1_req;
        size_q  <= SIZE;
        sign_q  <= SIGNED;
        base_q  <= base_req;
        wdata_q <= WDATA;
        rbuf    <= '0;
      end
      if (state == RD_CAP) begin
        rbuf <= rbuf_shift;
        cnt  <= cnt + 2'd1;
        // Load result is registered from the shifted buffer on DONE entry.
        if (last) rdata_q <= ext;
      end
      if (state == WR) cnt <= cnt + 2'd1;
    end
  end

  mem_load_extend #(
    .DATA_W (DATA_W)
  ) u_extend (
    .raw     (rbuf_shift),
    .size    (size_q),
    .sign_en (sign_q),
    .ext     (ext)
  );

  assign RDATA     = rdata_q;
  assign RAM_ADDR  = base_q + ADDR_W'(cnt);
  assign RAM_WDATA = (state == WR) ? wdata_q[{wsel, 3'b000} +: 8] : 8'h00;

endmodule

// File: doc/mem_byte_sequencer.md
# mem_byte_sequencer

Byte-serial memory access sequencer between the datapath's MAR/MDR and the 256x8 RAM. It converts one word, halfword or byte request into a sequence of single-byte RAM cycles. Bytes are ordered big-endian. The block assembles and extends load data and returns MOC to the control unit through a four-phase MFA/MOC handshake.

## Interface
Parameters:
- ADDR_W, 8, RAM address width (256 bytes).
- DATA_W, 32, datapath word width.

Ports:
- CLK  in  1  system clock; all state changes on rising edge.
- RESET  in  1  asynchronous, active-low reset.
- MFA  in  1  memory function activate, from the control unit.
- RW  in  1  1 = read (load), 0 = write (store).
- SIZE  in  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as word).
- SIGNED  in  1  sign-extend load data (see Configuration).
- ADDR  in  ADDR_W  byte address, from MAR.
- WDATA  in  DATA_W  store data, from MDR.
- RDATA  out  DATA_W  assembled and extended load data, to MDR mux.
- MOC  out  1  memory operation complete.
- RAM_EN  out  1  RAM enable.
- RAM_WE  out  1  RAM write enable.
- RAM_ADDR  out  ADDR_W  RAM byte address.
- RAM_WDATA  out  8  RAM write byte.
- RAM_RDATA  in  8  RAM read byte; synchronous, valid the cycle after address.

## Operation
- Request latch: in IDLE, MFA=1 latches RW, SIZE, SIGNED and WDATA, plus an aligned base address.
  - Word: ADDR[1:0] forced to 00.
  - Halfword: ADDR[0] forced to 0.
  - Byte: ADDR unchanged.
  - Byte count N = 1, 2 or 4. Counter cnt=0.
- States:
  - IDLE: RAM_EN=0, MOC=0. MFA=1 moves to RD_ADDR if RW=1, else to WR.
  - RD_ADDR: RAM_EN=1, RAM_WE=0, RAM_ADDR=base+cnt. Moves to RD_CAP.
  - RD_CAP: RAM_EN=0; rbuf <= {rbuf[23:0], RAM_RDATA}; cnt++. Moves to DONE if cnt==N-1, else to RD_ADDR.
  - WR: RAM_EN=1, RAM_WE=1, RAM_ADDR=base+cnt, RAM_WDATA = byte (N-1-cnt) of the low N bytes of WDATA, so the MSB goes to the lowest address. cnt++. Moves to DONE if cnt==N-1.
  - DONE: MOC=1; RDATA holds the extended rbuf (reads only). Stays in DONE while MFA=1; moves to IDLE when MFA=0.
- Addresses are computed modulo 256. Alignment means a request never crosses its word.
- RDATA changes only on entry to DONE and holds across IDLE until the next read completes. Writes leave RDATA unchanged.
- A write drives no RAM read cycles.
- MFA deasserted mid-transaction is ignored: the transaction completes, MOC pulses for exactly one cycle in DONE, then the block returns to IDLE.
- A new request is accepted only in IDLE. MFA held high through DONE does not retrigger.
- Reset, including mid-transaction: state=IDLE, cnt=0, MOC=0, RAM_EN=0, RAM_WE=0, RAM_ADDR=0, RAM_WDATA=0, RDATA=0, rbuf=0. A partial write may already have updated some RAM bytes.

## Timing
- Edge 0 is the edge that samples MFA=1 in IDLE.
- MOC goes high after the following edge and stays high until the edge after MFA is sampled 0:
  - Read: edge 2N (byte 2, halfword 4, word 8).
  - Write: edge N (byte 1, halfword 2, word 4).
- Back-to-back throughput: one IDLE cycle minimum between transactions.
- All outputs are registered or are decoded from registered state. There are no combinational paths from MFA to MOC.

## Configuration
- MEM_SEQ_SIGNEXT_EN defined: byte and halfword loads with SIGNED=1 are sign-extended to 32 bits. SIGNED=0 zero-extends.
- MEM_SEQ_SIGNEXT_EN undefined: the SIGNED input is ignored and all sub-word loads are zero-extended.
- Word loads are unaffected in both cases.

## Structure
- Shared package mem_seq_pkg holds:
  - SIZE encodings: SZ_BYTE, SZ_HALF, SZ_WORD.
  - The state enum: IDLE, RD_ADDR, RD_CAP, WR, DONE.
  - The byte-count function from SIZE.
- Sub-module mem_load_extend: combinational conversion of rbuf, SIZE and SIGNED to RDATA. The extend path under MEM_SEQ_SIGNEXT_EN lives here.

## Test plan
- Preload RAM[0x10..0x13] = DE AD BE EF. Word read at ADDR=0x12 -> RAM addresses 0x10, 0x11, 0x12, 0x13 in order; RDATA=0xDEADBEEF; MOC high after edge 8.
- Byte read at 0x11 with SIGNED=1 -> RDATA=0xFFFFFFAD with MEM_SEQ_SIGNEXT_EN, 0x000000AD without; MOC after edge 2.
- Halfword write WDATA=0x1234CAFE at 0x21 -> RAM[0x20]=0xCA, RAM[0x21]=0xFE, RAM[0x22] untouched; MOC after edge 2.
- Word write 0x01020304 at 0xFC -> RAM[0xFC..0xFF] = 01 02 03 04; no write to 0x00; MOC after edge 4.
- MFA held high 5 cycles past MOC -> MOC stays high, no second RAM access; MFA low -> MOC low next edge and IDLE. MFA dropped after edge 1 of a word read -> full 8-edge read completes with a 1-cycle MOC pulse.
- RESET low during RD_CAP of a word read -> MOC=0, RAM_EN=0, RDATA=0 immediately; after release, a byte read of 0x13 returns 0x000000EF normally.
